ifu_fetch: RTL and testbench

- Instruction fetch unit. It sits on the upstream side of the IFU→IDU valid/ready handshake and is the producer end of the decoder's IFU_valid/IDU_ready pair.
- It issues instruction reads on an AXI4-Lite read channel (AR/R) and registers the returned word with its PC.
- It presents the word to the decoder and advances to PC+4. A redirect from the execute/writeback stage overrides the next PC.
- One fetch is outstanding at a time. Responses made stale by a redirect are discarded.

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu_fetch.sv | 125 ++++++++++++
 tb/tb_ifu_fetch.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    ERR
  } state_t;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding AXI4-Lite read, registered
// word/PC toward the decoder, redirect with stale-response drop.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            IFU_valid,
  input  logic            IDU_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err
);

  state_t state_q, state_d;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pend_pc;
  logic            drop;

  logic            fetch_ld;
  logic [XLEN-1:0] fetch_nxt;
  logic            pend_ld;
  logic            drop_clr;
  logic            cap;
  logic            err_set;

  assign araddr = fetch_pc;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    IFU_valid = 1'b0;
    fetch_ld  = 1'b0;
    fetch_nxt = fetch_pc;
    pend_ld   = 1'b0;
    drop_clr  = 1'b0;
    cap       = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        arvalid = 1'b1;
        pend_ld = redirect_valid;
        if (arready) state_d = WAIT;
      end
      WAIT: begin
        rready = 1'b1;
        if (rvalid) begin
          // a redirect arriving with the data also squashes it
          if (drop || redirect_valid) begin
            fetch_ld  = 1'b1;
            fetch_nxt = redirect_valid ? redirect_pc : pend_pc;
            drop_clr  = 1'b1;
            state_d   = REQ;
          end else if (rresp != RESP_OKAY) begin
            err_set = 1'b1;
            state_d = ERR;
          end else begin
            cap     = 1'b1;
            state_d = HOLD;
          end
        end else begin
          pend_ld = redirect_valid;
        end
      end
      HOLD: begin
        IFU_valid = 1'b1;
        if (redirect_valid) begin
          fetch_ld  = 1'b1;
          fetch_nxt = redirect_pc;
          state_d   = REQ;
        end else if (IDU_ready) begin
          fetch_ld  = 1'b1;
          fetch_nxt = pc + XLEN'(4);
          state_d   = REQ;
        end
      end
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      pend_pc   <= RESET_PC;
      drop      <= 1'b0;
      pc        <= '0;
      inst      <= NOP_INST;
      fetch_err <= 1'b0;
    end else begin
      if (fetch_ld) fetch_pc <= fetch_nxt;
      if (pend_ld) begin
        pend_pc <= redirect_pc;
        drop    <= 1'b1;
      end
      if (drop_clr) drop <= 1'b0;
      if (cap) begin
        inst <= rdata;
        pc   <= fetch_pc;
      end
      if (err_set) fetch_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch with a
// transaction-level next-PC model and a behavioural memory.
module tb_ifu_fetch;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        IFU_valid;
  logic        IDU_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_err;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .pc(pc), .IFU_valid(IFU_valid), .IDU_ready(IDU_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected {pc, inst} of each decoder transfer
  logic [63:0] exp_q[$];
  logic [31:0] next_pc = RPC;

  // memory and stimulus knobs
  bit          mem_busy = 0;
  logic [31:0] mem_addr = '0;
  int          mem_delay = 0;
  int          delay_force = -1;
  int          ar_hold = 0;
  bit          zw = 1;
  bit          err_mode = 0;
  int          ready_mode = 1;
  int          redir_pct = 0;
  int          quiet = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RPC) return 32'h0000_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 4)
      0: return 32'h8000_0100;
      1: return 32'hFFFF_FFFC;
      2: return r & 32'hFFFF_FFFC;
      default: return r;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    rresp  = 2'b00;
    rdata  = '0;
    if (!rst) begin
      mem_busy = 0;
      exp_q.delete();
      next_pc = RPC;
      quiet = 3;
    end
    if (mem_busy) begin
      if (mem_delay > 0) mem_delay--;
      else begin
        rvalid = 1'b1;
        rdata  = mem_word(mem_addr);
        rresp  = err_mode ? 2'b10 : 2'b00;
        if (rready) mem_busy = 0;
      end
    end
    arready = 1'b0;
    if (rst && arvalid && !mem_busy) begin
      if (ar_hold > 0) ar_hold--;
      else arready = zw || ($urandom % 3 == 0);
      if (arready) begin
        mem_busy  = 1;
        mem_addr  = araddr;
        mem_delay = delay_force >= 0 ? delay_force :
                    (zw ? 0 : int'($urandom % 3));
      end
    end
    case (ready_mode)
      0: IDU_ready = 1'b0;
      1: IDU_ready = 1'b1;
      default: IDU_ready = ($urandom % 100) < 60;
    endcase
    redirect_valid = 1'b0;
    if (quiet > 0) quiet--;
    else if (rst && ($urandom % 100) < redir_pct) begin
      redirect_valid = 1'b1;
      redirect_pc = pick_target();
    end
    // transfer completes first, then any redirect picks the next PC
    if (rst && IFU_valid && IDU_ready) begin
      exp_q.push_back({next_pc, mem_word(next_pc)});
      next_pc = next_pc + 32'd4;
    end
    if (rst && redirect_valid) next_pc = redirect_pc;
  endtask

  task automatic inject(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    next_pc = t;
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return arvalid;
      1: return rready;
      2: return IFU_valid;
      default: return fetch_err;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name);
    int n;
    n = 0;
    while (!sig(sel) && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (!sig(sel)) begin
      errors++;
      $display("FAIL %s: timeout got 0 expected 1", name);
    end
  endtask

  // monitor: transfers, AR stability, held output stability
  logic        p_ar = 0;
  logic [31:0] p_addr = '0;
  logic        p_hold = 0;
  logic [31:0] p_pc = '0;
  logic [31:0] p_inst = '0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst && IFU_valid && IDU_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got pc %h expected none", pc);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_pc", pc, e[63:32]);
        chk("xfer_inst", inst, e[31:0]);
      end
    end
    if (rst && p_ar) begin
      chk("ar_stable_valid", {31'b0, arvalid}, 32'd1);
      chk("ar_stable_addr", araddr, p_addr);
    end
    if (rst && p_hold) begin
      chk("hold_valid", {31'b0, IFU_valid}, 32'd1);
      chk("hold_pc", pc, p_pc);
      chk("hold_inst", inst, p_inst);
    end
    p_ar   = rst && arvalid && !arready;
    p_addr = araddr;
    p_hold = rst && IFU_valid && !IDU_ready && !redirect_valid;
    p_pc   = pc;
    p_inst = inst;
  end

  logic [31:0] exp_a;

  initial begin
    // reset and first fetch with zero-wait memory
    zw = 1;
    ready_mode = 1;
    rst = 1'b0;
    step();
    step();
    chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("rst_rready", {31'b0, rready}, 32'd0);
    chk("rst_ifu_valid", {31'b0, IFU_valid}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    rst = 1'b1;
    step();
    chk("c2_arvalid", {31'b0, arvalid}, 32'd1);
    chk("c2_araddr", araddr, RPC);
    step();
    chk("c3_rready", {31'b0, rready}, 32'd1);
    step();
    chk("c4_ifu_valid", {31'b0, IFU_valid}, 32'd1);
    chk("c4_inst", inst, 32'h0000_0093);
    chk("c4_pc", pc, RPC);
    step();
    chk("c5_araddr", araddr, RPC + 32'd4);

    // backpressure in HOLD
    ready_mode = 0;
    wait_for(2, "bp_valid");
    exp_a = next_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", {31'b0, IFU_valid}, 32'd1);
      chk("bp_no_ar", {31'b0, arvalid}, 32'd0);
      chk("bp_pc", pc, exp_a);
    end
    ready_mode = 1;
    step();
    step();
    chk("bp_next_ar", {31'b0, arvalid}, 32'd1);
    chk("bp_next_addr", araddr, exp_a + 32'd4);

    // redirect while waiting for read data
    zw = 0;
    delay_force = 2;
    wait_for(1, "rw_wait");
    inject(32'h8000_0100);
    wait_for(0, "rw_ar");
    chk("rw_araddr", araddr, 32'h8000_0100);
    delay_force = -1;
    wait_for(2, "rw_valid");
    chk("rw_pc", pc, 32'h8000_0100);
    chk("rw_inst", inst, mem_word(32'h8000_0100));

    // redirect in REQ with delayed arready
    ar_hold = 3;
    wait_for(0, "rq_ar");
    exp_a = next_pc;
    inject(32'h8000_0200);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rq_hold_addr", araddr, exp_a);
    end
    wait_for(1, "rq_wait");
    wait_for(0, "rq_ar2");
    chk("rq_araddr", araddr, 32'h8000_0200);

    // wrap of pc+4
    ready_mode = 0;
    wait_for(2, "wr_valid0");
    inject(32'hFFFF_FFFC);
    step();
    wait_for(2, "wr_valid");
    chk("wr_pc", pc, 32'hFFFF_FFFC);
    ready_mode = 1;
    step();
    step();
    chk("wr_ar", {31'b0, arvalid}, 32'd1);
    chk("wr_araddr", araddr, 32'h0000_0000);

    // randomized traffic
    ready_mode = 2;
    redir_pct = 8;
    for (int i = 0; i < 3000; i++) step();

    // bus error, then recovery through reset
    redir_pct = 0;
    err_mode = 1;
    wait_for(3, "err_flag");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("err_no_ar", {31'b0, arvalid}, 32'd0);
      chk("err_no_valid", {31'b0, IFU_valid}, 32'd0);
      chk("err_sticky", {31'b0, fetch_err}, 32'd1);
    end
    inject(32'h8000_0300);
    step();
    step();
    chk("err_redir_ignored", {31'b0, arvalid}, 32'd0);
    err_mode = 0;
    rst = 1'b0;
    step();
    chk("err_rst_flag", {31'b0, fetch_err}, 32'd0);
    chk("err_rst_ar", {31'b0, arvalid}, 32'd0);
    rst = 1'b1;
    wait_for(0, "err_restart");
    chk("err_restart_addr", araddr, RPC);
    ready_mode = 1;
    wait_for(2, "err_restart_valid");
    chk("err_restart_pc", pc, RPC);
    ready_mode = 2;
    redir_pct = 8;
    for (int i = 0; i < 200; i++) step();
    redir_pct = 0;
    ready_mode = 1;
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
